// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between a producer/consumer and sync_fifo_param.
// The master side drives requests and data; the FIFO (slave) drives status.
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  flush;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, wr_en, rd_en, data_in,
        input  data_out, full, empty, almost_full, almost_empty,
        input  count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, rd_en, data_in,
        output data_out, full, empty, almost_full, almost_empty,
        output count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, programmable almost flags,
// synchronous flush and registered overflow/underflow pulses.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_param_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic full, empty, wr_acc, rd_acc;

    // Status flags depend only on the registered count, never on this cycle's requests.
    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (int'(count_q) >= AF_LEVEL);
    assign bus.almost_empty = (int'(count_q) <= AE_LEVEL);
    assign bus.count        = count_q;
    assign bus.data_out     = dout_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

    assign wr_acc = bus.wr_en && !full  && !bus.flush;
    assign rd_acc = bus.rd_en && !empty && !bus.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (bus.flush) begin
            // Contents become unreachable; data_out keeps its last value.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            ovf_d = bus.wr_en && full;
            unf_d = bus.rd_en && empty;
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                dout_d   = mem[rd_ptr_q];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= bus.data_in;
    end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO, the next-generation replacement for the fixed-size FIFO used in the fifo test environment. It adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and overflow/underflow error pulses. It sits between a single-clock producer and consumer and is driven by the existing fifo interface/test classes, extended with the new signals.

## Interface
- DATA_WIDTH, 8, width of data_in/data_out
- DEPTH, 16, number of entries; power of two, >= 2
- AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of contents, active high
- wr_en  input  1  write request
- rd_en  input  1  read request
- data_in  input  DATA_WIDTH  write data
- data_out  output  DATA_WIDTH  registered read data
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL
- almost_empty  output  1  count <= AE_LEVEL
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse: write rejected because full
- underflow  output  1  one-cycle pulse: read rejected because empty

## Operation
- Storage: DEPTH x DATA_WIDTH array; wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally; count is tracked in a separate register.
- Write accepted iff wr_en && !full (full sampled before the edge): mem[wr_ptr] <= data_in, wr_ptr++.
- Read accepted iff rd_en && !empty: data_out <= mem[rd_ptr], rd_ptr++. On all other cycles data_out holds.
- Count: +1 for write-only, -1 for read-only, unchanged when both are accepted or neither is.
- Simultaneous wr_en && rd_en:
  - Neither full nor empty: both accepted; count unchanged.
  - When full: the read is accepted; the write is rejected and overflow pulses.
  - When empty: the write is accepted; the read is rejected and underflow pulses. Read-during-write to an empty FIFO does not bypass.
- flush (priority over wr_en/rd_en):
  - Next edge clears wr_ptr, rd_ptr and count.
  - Ignores wr_en/rd_en that cycle; no overflow/underflow pulse.
  - data_out holds; memory contents are not cleared.
- Flags full, empty, almost_full and almost_empty are combinational decodes of the registered count only; no path from wr_en/rd_en.
- overflow/underflow are registered; high for exactly the cycle after the offending edge.
- Reset (rst low, asynchronous):
  - Pointers, count, data_out, overflow and underflow go to 0.
  - Giving empty=1, almost_empty=1, full=0, almost_full=0 (almost_full=1 only if AF_LEVEL==0).
  - Memory is not reset.
  - Reset deasserts synchronously to clk (external synchroniser); reset mid-operation discards all contents.

## Timing
- Write latency: an entry is readable (empty falls) on the cycle after the write edge; the earliest rd_en edge that can return it is the next edge.
- Read latency: 1 cycle. data_out is valid after the edge at which rd_en && !empty was sampled.
- Flags and count reflect all accepted operations one edge after acceptance.
- Back-to-back writes and reads are sustainable at one per cycle each (100% throughput).
- Single clock domain; no gray coding required.

## Test plan
(DATA_WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2 unless noted)
- Reset: hold rst low 2 cycles mid-traffic -> count=0, empty=1, almost_empty=1, full=0, data_out=0x00, overflow=underflow=0. After release, the first read returns the first post-reset write.
- Fill/drain order: write 0x01..0x08 -> almost_full rises after the 6th write, full=1 and count=8 after the 8th. Read 8 times -> data_out sequence 0x01..0x08, one per cycle, then empty=1.
- Overflow: with full=1, assert wr_en with 0xAA -> overflow pulses for 1 cycle, count stays 8, 0xAA is never read back.
- Underflow and simultaneous access on empty: wr_en+rd_en with data 0x55 while empty -> underflow=1 for 1 cycle, count=1. The next read returns 0x55.
- Simultaneous on full: wr_en=1 (0x99) + rd_en=1 -> read returns the oldest entry, overflow=1, count=7.
- Wrap and flush: run 20 write/read pairs at count≈3 (pointers wrap twice) -> data in order, count constant. Then assert flush together with wr_en -> count=0, empty=1, no overflow, data_out unchanged.
